div_iter: RTL

Multi-cycle, parametrised integer divider for the M-extension execute stage. It is the sequential successor to the single-cycle `div` unit. It implements div/divu/rem/remu and their 32-bit word forms (divw/divuw/remw/remuw) with a radix-2 restoring datapath that produces one quotient bit per cycle. A valid/ready handshake lets the pipeline stall on it, and a flush input aborts an in-flight operation.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/div_iter_if.sv | 30 +++
 rtl/div_step.sv | 26 ++
 rtl/div_iter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU/divider definitions: control encodings and divider FSM states.
// Used by div, div_iter and the execute-stage decoder.
package alu_pkg;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } div_state_e;

  function automatic logic is_signed(input logic [1:0] ctl);
    return (ctl == DIV) || (ctl == REM);
  endfunction

  function automatic logic is_rem(input logic [1:0] ctl);
    return (ctl == REM) || (ctl == REMU);
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response handshake bundle between the execute stage and div_iter.
// master = pipeline side, slave = divider side.
interface div_iter_if #(
  parameter int XLEN = 64
);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic [1:0]      control;
  logic            word_op;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;

  modport master (
    output in_valid, in1, in2, control,
    output word_op, flush, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in1, in2, control,
    input  word_op, flush, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quot}, trial-subtract,
// keep the difference if non-negative and shift in the quotient bit.
module div_step
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN:0]   rem_nxt,
  output logic [XLEN-1:0] quot_nxt
);

  logic [XLEN+1:0] sh;
  logic [XLEN+1:0] diff;
  logic            ge;

  assign sh   = {rem, quot[XLEN-1]};
  assign diff = sh - {2'b00, dvsr};
  assign ge   = !diff[XLEN+1];

  assign rem_nxt  = ge ? diff[XLEN:0] : sh[XLEN:0];
  assign quot_nxt = {quot[XLEN-2:0], ge};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for div/divu/rem/remu and W forms.
// One quotient bit per cycle; special cases skip the iteration loop.
module div_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic     clk,
  input logic     rst_n,
  div_iter_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [XLEN-1:0] MIN_X =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W =
    {{(XLEN-31){1'b1}}, 31'b0};

  div_state_e state, state_nxt;

  logic [CW-1:0]   cnt;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] dvsr;
  logic            rem_op;
  logic            wop_q;
  logic            sa_q;
  logic            sb_q;
  logic [XLEN-1:0] res;

  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quot_nxt;

  logic            wop;
  logic            sgn;
  logic [XLEN-1:0] a_op;
  logic [XLEN-1:0] b_op;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div0;
  logic            ovf;
  logic            accept;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] sel;
  logic [XLEN-1:0] res_nxt;

  function automatic logic [XLEN-1:0] sext32(
    input logic [XLEN-1:0] x
  );
    return XLEN'(signed'(x[31:0]));
  endfunction

  function automatic logic [XLEN-1:0] zext32(
    input logic [XLEN-1:0] x
  );
    return XLEN'(x[31:0]);
  endfunction

  // Word operands are widened first so one datapath serves both forms
  assign wop  = (XLEN == 64) && bus.word_op;
  assign sgn  = is_signed(bus.control);
  assign a_op = !wop ? bus.in1 :
                sgn  ? sext32(bus.in1) : zext32(bus.in1);
  assign b_op = !wop ? bus.in2 :
                sgn  ? sext32(bus.in2) : zext32(bus.in2);

  assign sa    = sgn && a_op[XLEN-1];
  assign sb    = sgn && b_op[XLEN-1];
  assign a_abs = sa ? -a_op : a_op;
  assign b_abs = sb ? -b_op : b_op;

  assign div0 = (b_op == '0);
  assign ovf  = sgn && (&b_op) &&
                (a_op == (wop ? MIN_W : MIN_X));

  assign accept = (state == IDLE) && bus.in_valid &&
                  !bus.flush;

  div_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem      (rem),
    .quot     (quot),
    .dvsr     (dvsr),
    .rem_nxt  (rem_nxt),
    .quot_nxt (quot_nxt)
  );

  assign q_fix   = (sa_q ^ sb_q) ? -quot : quot;
  assign r_fix   = sa_q ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  assign sel     = rem_op ? r_fix : q_fix;
  assign res_nxt = wop_q ? sext32(sel) : sel;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)
              state_nxt = (div0 || ovf) ? FIX : BUSY;
      BUSY: if (cnt == CW'(1))
              state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready)
              state_nxt = IDLE;
    endcase
    if (bus.flush)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quot   <= '0;
      dvsr   <= '0;
      rem_op <= 1'b0;
      wop_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      res    <= '0;
    end else begin
      state <= state_nxt;
      if (bus.flush) begin
        cnt <= '0;
      end else if (accept) begin
        rem_op <= is_rem(bus.control);
        wop_q  <= wop;
        dvsr   <= b_abs;
        // Special results are staged raw; FIX only sign-extends them
        if (div0 || ovf) begin
          cnt  <= '0;
          sa_q <= 1'b0;
          sb_q <= 1'b0;
          quot <= div0 ? '1 : bus.in1;
          rem  <= div0 ? {1'b0, bus.in1} : '0;
        end else begin
          cnt  <= wop ? CW'(32) : CW'(XLEN);
          sa_q <= sa;
          sb_q <= sb;
          quot <= wop ? (a_abs << (XLEN - 32)) : a_abs;
          rem  <= '0;
        end
      end else if (state == BUSY) begin
        rem  <= rem_nxt;
        quot <= quot_nxt;
        cnt  <= cnt - CW'(1);
      end else if (state == FIX) begin
        res <= res_nxt;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = res;

endmodule
